shared_op_sched: RTL and testbench
==================================

Name: shared_op_sched

Overview:
- Round-robin scheduler that shares one arithmetic/accumulator unit between N_REQ requesters.
- Each requester submits an operation and operand through a valid/ready handshake. The block grants at most one request per cycle and runs it through a 2-stage pipeline.
- It returns a tagged result and owns the single shared accumulator register.
- Sits between multiple tock-style callers and the one physical function unit, so callers never touch the unit directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result/accumulator width.
- ID_W, $clog2(N_REQ), requester tag width (derived; not overridden).

Ports:
- clock  in  1  sole clock; all state on posedge clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  when low, no new grants; the pipeline still drains.
- req_valid  in  N_REQ  per-requester request valid.
- req_op  in  N_REQ x 2  per-requester opcode.
- req_x  in  N_REQ x WIDTH  per-requester operand.
- req_ready  out  N_REQ  one-hot grant, combinational.
- resp_valid  out  1  result valid, one-cycle pulse per accepted request.
- resp_id  out  ID_W  index of the requester that issued this result.
- resp_data  out  WIDTH  result.
- acc_value  out  WIDTH  current accumulator contents.
- busy  out  1  either pipeline stage holds a valid op.

Behaviour:
- Clock and reset: one clock (clock); reset (rst_n) is synchronous and active-low.
- Reset values: resp_valid=0, resp_id=0, resp_data=0, acc_value=0, busy=0; priority pointer=0; both stage valids=0.
- Reset mid-operation drops any in-flight ops; no response is emitted for them.
- Opcodes:
  - 0 INC: x+1.
  - 1 ADD12: x+12.
  - 2 ACC: acc<=acc+x; result = new acc.
  - 3 CLR: acc<=0; result = 0.
- Arithmetic: all sums wrap modulo 2^WIDTH, unsigned; no overflow flag.
- Arbitration:
  - Search starts at the priority pointer p and takes the first i (p, p+1, ... mod N_REQ) with req_valid[i]=1.
  - req_ready[i]=1 only for that i, and only when enable=1 and rst_n=1.
  - A handshake occurs on req_valid[i] & req_ready[i].
  - After a grant to i, p <= (i+1) mod N_REQ. With no grant, p holds.
- Handshake rules:
  - The unit never stalls; there is no response backpressure. A grant is therefore never blocked by pipeline occupancy.
  - A requester must hold op/x stable while valid is high and not granted.
- Pipeline:
  - Stage 1 registers {op, x, id} at the grant edge.
  - Stage 2 computes and registers resp_* and the acc update.
  - Latency: a request accepted at edge T yields resp_valid high in the cycle after edge T+1. Throughput is 1 per cycle.
- Back-to-back ACC/CLR: accumulator updates occur in stage 2 in grant order, so consecutive ACC ops see each other's results with no hazard.
- acc_value reflects the registered accumulator; it updates in the same cycle resp_valid shows the ACC/CLR result.
- busy = s1_valid | s2_valid (s2_valid is the registered resp_valid).
- enable deasserted mid-stream: in-flight ops complete, no new grants, and p is unchanged.

Optional Feature:
- Macro SHARED_OP_SCHED_PERF_EN.
- Defined:
  - Adds output grant_count (32 bits) and output starve_max (16 bits).
  - grant_count counts handshakes, wraps, reset 0.
  - starve_max holds the largest number of consecutive cycles any single requester has had valid high without a grant. It saturates at 0xFFFF, reset 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package shared_op_pkg holds:
  - the op enum (OP_INC=0, OP_ADD12=1, OP_ACC=2, OP_CLR=3);
  - the constant ADD12_K=12;
  - the stage-1 payload struct {op, x, id}.
- Sub-module rr_arbiter (N parameter) holds:
  - inputs: req vector, enable;
  - outputs: one-hot grant, grant index, grant_any;
  - state: the rotating priority pointer.
- The datapath and accumulator stay in shared_op_sched.

Test Plan:
- Reset, then req0 INC x=5 alone → req_ready[0] same cycle; two edges later resp_valid=1, resp_id=0, resp_data=6; busy low afterwards.
- All 4 requesters hold ADD12 x=i continuously → grants go 0,1,2,3,0,… one per cycle; responses have resp_data=12+i in the same order, 2 cycles behind.
- ACC x=3, ACC x=4 back-to-back, then CLR, then ACC x=0xFFFFFFFF twice → resp_data 3, 7, 0, 0xFFFFFFFF, 0xFFFFFFFE (wrap); acc_value tracks each.
- enable low with req1 valid for 5 cycles → req_ready stays 0; raise enable → req1 granted next cycle; p advances to 2.
- rst_n low one cycle while two ops are in flight → no resp_valid for them; acc_value=0; the next grant goes to the lowest-index valid requester.
- PERF build: req3 valid while req0–2 saturate for 3 cycles → starve_max=3; grant_count matches the handshake total.

Source files
------------

// File: rtl/shared_op_pkg.sv
// shared_op_pkg: opcode enum, ADD12 constant and stage-1 payload type for shared_op_sched
package shared_op_pkg;
  typedef enum logic [1:0] {OP_INC = 2'd0, OP_ADD12 = 2'd1, OP_ACC = 2'd2, OP_CLR = 2'd3} op_e;
  localparam int ADD12_K = 12;
  localparam int X_MAX_W = 64;
  localparam int ID_MAX_W = 3;
  typedef struct packed {
    op_e                 op;
    logic [X_MAX_W-1:0]  x;
    logic [ID_MAX_W-1:0] id;
  } s1_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant with a rotating priority pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          i_clock,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] r_ptr;
  // first valid requester at or after the pointer wins
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_enable && !o_any && i_req[(int'(r_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(r_ptr) + k) % N);
        o_grant[(int'(r_ptr) + k) % N] = 1'b1;
      end
    end
  end
  // pointer moves just past the winner, holds when nobody is granted
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) r_ptr <= '0;
    else if (o_any) r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
  end
endmodule

// File: rtl/shared_op_sched.sv
// shared_op_sched: round-robin sharing of one 2-stage arithmetic/accumulator unit; SHARED_OP_SCHED_PERF_EN adds grant/starvation counters
module shared_op_sched
  import shared_op_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   i_clock,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*2-1:0]     i_req_op,
  input  logic [N_REQ*WIDTH-1:0] i_req_x,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_resp_valid,
  output logic [ID_W-1:0]        o_resp_id,
  output logic [WIDTH-1:0]       o_resp_data,
  output logic [WIDTH-1:0]       o_acc_value,
  output logic                   o_busy
`ifdef SHARED_OP_SCHED_PERF_EN
  , output logic [31:0]          o_grant_count
  , output logic [15:0]          o_starve_max
`endif
);
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  op_e              w_op;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_sx;
  logic [WIDTH-1:0] w_result;
  logic             r_s1_valid;
  s1_t              r_s1;
  logic             r_resp_valid;
  logic [ID_W-1:0]  r_resp_id;
  logic [WIDTH-1:0] r_resp_data;
  logic [WIDTH-1:0] r_acc;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_clock (i_clock),
    .i_rst_n (i_rst_n),
    .i_req   (i_req_valid),
    .i_enable(i_enable & i_rst_n),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign o_req_ready = w_grant;
  assign w_op = op_e'(i_req_op[int'(w_idx)*2 +: 2]);
  assign w_x = i_req_x[int'(w_idx)*WIDTH +: WIDTH];
  assign w_sx = WIDTH'(r_s1.x);
  assign w_result = (r_s1.op == OP_INC)   ? w_sx + 1'b1 :
                    (r_s1.op == OP_ADD12) ? w_sx + WIDTH'(ADD12_K) :
                    (r_s1.op == OP_ACC)   ? r_acc + w_sx : '0;

  // stage 1 captures the granted request
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1 <= '0;
    end else begin
      r_s1_valid <= w_any;
      if (w_any) r_s1 <= '{op: w_op, x: X_MAX_W'(w_x), id: ID_MAX_W'(w_idx)};
    end
  end

  // stage 2 computes the result and applies accumulator updates in grant order
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id <= '0;
      r_resp_data <= '0;
      r_acc <= '0;
    end else begin
      r_resp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_resp_id <= ID_W'(r_s1.id);
        r_resp_data <= w_result;
        if (r_s1.op == OP_ACC || r_s1.op == OP_CLR) r_acc <= w_result;
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_id = r_resp_id;
  assign o_resp_data = r_resp_data;
  assign o_acc_value = r_acc;
  assign o_busy = r_s1_valid | r_resp_valid;

`ifdef SHARED_OP_SCHED_PERF_EN
  logic [31:0] r_grant_count;
  logic [15:0] r_starve_max;
  logic [15:0] r_starve [N_REQ];
  logic [15:0] w_starve_nxt [N_REQ];
  logic [15:0] w_starve_top;
  // per-requester wait runs (saturating) and the largest run seen so far
  always_comb begin
    w_starve_top = r_starve_max;
    for (int i = 0; i < N_REQ; i++) begin
      w_starve_nxt[i] = (i_req_valid[i] && !o_req_ready[i]) ? r_starve[i] + {15'd0, r_starve[i] != 16'hFFFF} : '0;
      w_starve_top = (w_starve_nxt[i] > w_starve_top) ? w_starve_nxt[i] : w_starve_top;
    end
  end
  // handshake counter and starvation registers
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_grant_count <= '0;
      r_starve_max <= '0;
      for (int i = 0; i < N_REQ; i++) r_starve[i] <= '0;
    end else begin
      r_grant_count <= r_grant_count + 32'(w_any);
      r_starve_max <= w_starve_top;
      for (int i = 0; i < N_REQ; i++) r_starve[i] <= w_starve_nxt[i];
    end
  end
  assign o_grant_count = r_grant_count;
  assign o_starve_max = r_starve_max;
`endif
endmodule

// File: tb/tb_shared_op_sched.sv
// tb_shared_op_sched: directed and randomized checks of shared_op_sched against a queue-based reference
module tb_shared_op_sched;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IW = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en;
  logic [N-1:0] rv;
  logic [2*N-1:0] rop;
  logic [N*W-1:0] rx;
  logic [N-1:0] o_req_ready;
  logic o_resp_valid, o_busy;
  logic [IW-1:0] o_resp_id;
  logic [W-1:0] o_resp_data, o_acc_value;
`ifdef SHARED_OP_SCHED_PERF_EN
  logic [31:0] o_grant_count;
  logic [15:0] o_starve_max;
`endif

  shared_op_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .i_clock(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_req_valid(rv), .i_req_op(rop), .i_req_x(rx),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_resp_id(o_resp_id),
    .o_resp_data(o_resp_data), .o_acc_value(o_acc_value), .o_busy(o_busy)
`ifdef SHARED_OP_SCHED_PERF_EN
    , .o_grant_count(o_grant_count), .o_starve_max(o_starve_max)
`endif
  );

  typedef struct {int due; int id; logic [W-1:0] data; logic [W-1:0] acc;} resp_t;
  resp_t q[$];
  int checks = 0, errors = 0;
  int p = 0, n = 0, last_g = -1, perf_grants = 0;
  logic [W-1:0] m_acc = '0, m_acc_vis = '0;
  logic v[N];
  logic [1:0] op[N];
  logic [W-1:0] x[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (!rst_n || !en) return -1;
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] exec(input logic [1:0] o, input logic [W-1:0] xv);
    case (o)
      2'd0: return xv + 1;
      2'd1: return xv + 12;
      2'd2: begin m_acc = m_acc + xv; return m_acc; end
      default: begin m_acc = '0; return '0; end
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rv[i] = v[i];
      rop[2*i +: 2] = op[i];
      rx[W*i +: W] = x[i];
    end
  endtask

  task automatic tick();
    int g;
    logic [N-1:0] er;
    drive();
    @(negedge clk);
    g = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", o_req_ready, er);
    chk("busy", o_busy, q.size() != 0);
    if (q.size() != 0 && q[0].due == n) begin
      chk("resp_valid", o_resp_valid, 1);
      chk("resp_id", o_resp_id, q[0].id);
      chk("resp_data", o_resp_data, q[0].data);
      chk("acc_value", o_acc_value, q[0].acc);
      m_acc_vis = q[0].acc;
      void'(q.pop_front());
    end else begin
      chk("resp_idle", o_resp_valid, 0);
      chk("acc_hold", o_acc_value, m_acc_vis);
    end
    @(posedge clk);
    n++;
    last_g = g;
    if (!rst_n) begin
      q.delete();
      p = 0;
      m_acc = '0;
      m_acc_vis = '0;
      perf_grants = 0;
    end else if (g >= 0) begin
      logic [W-1:0] d;
      d = exec(op[g], x[g]);
      q.push_back('{n + 1, g, d, m_acc});
      p = (g + 1) % N;
      perf_grants++;
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; op[i] = '0; x[i] = '0;
    end
  endtask

  initial begin
    clear_reqs();
    rst_n = 1'b0;
    en = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_id", o_resp_id, 0);
    chk("rst_resp_data", o_resp_data, 0);
    chk("rst_acc", o_acc_value, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_req_ready, 0);
    rst_n = 1'b1;
    v[0] = 1'b1; op[0] = 2'd0; x[0] = 32'd5;
    tick();
    clear_reqs();
    tick();
    tick();
    chk("inc_data", o_resp_data, 32'd6);
    tick();
    chk("inc_busy_after", o_busy, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; op[i] = 2'd1; x[i] = W'(i);
    end
    repeat (8) tick();
    clear_reqs();
    repeat (3) tick();
    v[0] = 1'b1;
    op[0] = 2'd2; x[0] = 32'd3; tick();
    op[0] = 2'd2; x[0] = 32'd4; tick();
    op[0] = 2'd3; x[0] = 32'd0; tick();
    op[0] = 2'd2; x[0] = 32'hFFFF_FFFF; tick();
    tick();
    clear_reqs();
    repeat (3) tick();
    chk("acc_wrap", o_acc_value, 32'hFFFF_FFFE);
    en = 1'b0;
    v[1] = 1'b1; op[1] = 2'd0; x[1] = 32'd7;
    repeat (5) tick();
    en = 1'b1;
    tick();
    v[1] = 1'b0;
    v[0] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
    tick();
    chk("ptr_after_enable", p, 3);
    clear_reqs();
    repeat (3) tick();
    v[0] = 1'b1; op[0] = 2'd2; x[0] = 32'd9;
    v[1] = 1'b1; op[1] = 2'd1; x[1] = 32'd1;
    tick();
    tick();
    clear_reqs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_resp_valid", o_resp_valid, 0);
    chk("midrst_acc", o_acc_value, 0);
    chk("midrst_busy", o_busy, 0);
    v[2] = 1'b1; v[3] = 1'b1;
    tick();
    chk("midrst_first_grant", last_g, 2);
    clear_reqs();
    repeat (3) tick();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      for (int i = 0; i < N; i++) begin
        if (!v[i] || i == last_g) begin
          v[i] = $urandom_range(0, 1);
          op[i] = 2'($urandom_range(0, 3));
          x[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : 32'($urandom);
        end
      end
    end
    en = 1'b1;
    clear_reqs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; op[i] = 2'd1; x[i] = W'(i);
    end
    repeat (4) tick();
`ifdef SHARED_OP_SCHED_PERF_EN
    chk("starve_max", o_starve_max, 16'd3);
    chk("grant_count", o_grant_count, perf_grants);
`endif
    clear_reqs();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
